// File: rtl/iter_math_sequencer_pkg.sv
// iter_math_sequencer_pkg: shared state encoding, opcode values and default width
package iter_math_sequencer_pkg;
    localparam int W_DEF = 16;
    localparam logic OP_POWER = 1'b0;
    localparam logic OP_FACT = 1'b1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/iter_math_sequencer_if.sv
// iter_math_sequencer_if: request/response bundle between processor and sequencer
interface iter_math_sequencer_if import iter_math_sequencer_pkg::*; #(parameter int W = W_DEF);
    logic start, op, abort, busy, stall, done, overflow;
    logic [W-1:0] base, n, result;
    modport master(output start, op, base, n, abort, input busy, stall, done, result, overflow);
    modport slave(input start, op, base, n, abort, output busy, stall, done, result, overflow);
endinterface

// File: rtl/iter_math_sequencer_mul_step.sv
// mul_step: W x W multiply giving the low word and a flag for a nonzero high word
module mul_step #(parameter int W = 16) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic         ovf
);
    logic [2*W-1:0] p;
    assign p = a * b;
    assign lo = p[W-1:0];
    assign ovf = |p[2*W-1:W];
endmodule

// File: rtl/iter_math_sequencer.sv
// iter_math_sequencer: multicycle power/factorial sequencer around one shared multiplier
module iter_math_sequencer import iter_math_sequencer_pkg::*; #(parameter int W = W_DEF) (
    input logic clk,
    input logic rst,
    iter_math_sequencer_if.slave bus
);
    state_t state, state_next;
    logic op_q, ovf, last, accept;
    logic [W-1:0] base_q, acc, cnt, lo, result, b_sel;
    logic overflow;
    assign last = cnt == W'(1);
    assign accept = state == IDLE && bus.start;
    assign b_sel = op_q == OP_FACT ? cnt : base_q;
    mul_step #(.W(W)) u_mul (.a(acc), .b(b_sel), .lo(lo), .ovf(ovf));
    always_comb begin
        state_next = state;
        state_next = state == IDLE ? (bus.start ? (bus.n == '0 ? DONE : RUN) : IDLE) :
                     state == RUN  ? (bus.abort ? IDLE : (last ? DONE : RUN)) : IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_next;
    // abort leaves result/overflow untouched and outranks completion on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= 1'b0;
            base_q <= '0;
            acc <= '0;
            cnt <= '0;
            result <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            op_q <= bus.op;
            base_q <= bus.base;
            acc <= W'(1);
            cnt <= bus.n;
            overflow <= 1'b0;
            if (bus.n == '0) result <= W'(1);
        end else if (state == RUN && !bus.abort) begin
            acc <= lo;
            cnt <= last ? cnt : cnt - 1'b1;
            overflow <= overflow | ovf;
            if (last) result <= lo;
        end
    end
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.stall = state == RUN || accept;
    assign bus.result = result;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_iter_math_sequencer.sv
// tb_iter_math_sequencer: scoreboard bench for power/factorial sequencing, abort and reset
module tb_iter_math_sequencer;
    typedef struct { logic [15:0] res; logic ovf; } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    int n_done = 0;
    exp_t sb[$];
    iter_math_sequencer_if #(16) bus();
    iter_math_sequencer #(.W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("result", {16'h0, bus.result}, {16'h0, e.res});
                check("overflow", {31'h0, bus.overflow}, {31'h0, e.ovf});
            end
        end
    end

    task automatic run_op(input logic o, input logic [15:0] b, input logic [15:0] k,
                          input logic [15:0] r, input logic v);
        int lat;
        logic stall_ok, busy_seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.base = b; bus.n = k;
        sb.push_back('{r, v});
        #1 check("stall_req", {31'h0, bus.stall}, 1);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1; stall_ok = 1'b1; busy_seen = 1'b0;
        while (!bus.done && lat < 200) begin
            stall_ok &= bus.stall;
            busy_seen |= bus.busy;
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 32'(k) + 1);
        check("stall_run", {31'h0, stall_ok}, 1);
        check("busy_seen", {31'h0, busy_seen}, {31'h0, k != 0});
        check("stall_done", {31'h0, bus.stall}, 0);
        @(negedge clk);
        check("done_pulse", {31'h0, bus.done}, 0);
    endtask

    initial begin
        int d0;
        bus.start = 1'b0; bus.op = 1'b0; bus.base = '0; bus.n = '0; bus.abort = 1'b0;
        #12;
        check("rst_busy", {31'h0, bus.busy}, 0);
        check("rst_done", {31'h0, bus.done}, 0);
        check("rst_stall", {31'h0, bus.stall}, 0);
        check("rst_result", {16'h0, bus.result}, 0);
        check("rst_ovf", {31'h0, bus.overflow}, 0);
        @(negedge clk); rst = 1'b0;
        run_op(1'b0, 16'd3, 16'd4, 16'd81, 1'b0);
        run_op(1'b1, 16'd0, 16'd5, 16'd120, 1'b0);
        // abort factorial 6 during its second RUN cycle
        d0 = n_done;
        @(negedge clk); bus.start = 1'b1; bus.op = 1'b1; bus.n = 16'd6;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        check("abort_busy", {31'h0, bus.busy}, 0);
        check("abort_result", {16'h0, bus.result}, 120);
        check("abort_ovf", {31'h0, bus.overflow}, 0);
        repeat (6) @(negedge clk);
        check("abort_no_done", n_done, d0);
        run_op(1'b0, 16'd2, 16'd3, 16'd8, 1'b0);
        run_op(1'b1, 16'd0, 16'd8, 16'h9D80, 1'b0);
        run_op(1'b1, 16'd0, 16'd9, 16'h8980, 1'b1);
        run_op(1'b0, 16'd5, 16'd0, 16'd1, 1'b0);
        run_op(1'b1, 16'd7, 16'd0, 16'd1, 1'b0);
        run_op(1'b0, 16'd2, 16'd16, 16'd0, 1'b1);
        run_op(1'b0, 16'd0, 16'd3, 16'd0, 1'b0);
        // start held high through RUN and the done cycle must not launch a second op
        d0 = n_done;
        @(negedge clk); bus.start = 1'b1; bus.op = 1'b0; bus.base = 16'd3; bus.n = 16'd2;
        sb.push_back('{16'd9, 1'b0});
        @(negedge clk); bus.base = 16'd7; bus.n = 16'd5;
        @(negedge clk);
        @(negedge clk);
        check("hold_done", {31'h0, bus.done}, 1);
        @(negedge clk); bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_one_done", n_done, d0 + 1);
        check("hold_result", {16'h0, bus.result}, 9);
        check("hold_busy", {31'h0, bus.busy}, 0);
        // async reset between edges while running after an overflowing op
        run_op(1'b1, 16'd0, 16'd9, 16'h8980, 1'b1);
        @(negedge clk); bus.start = 1'b1; bus.op = 1'b1; bus.n = 16'd6;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", {31'h0, bus.busy}, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'h0, bus.busy}, 0);
        check("arst_stall", {31'h0, bus.stall}, 0);
        check("arst_result", {16'h0, bus.result}, 0);
        check("arst_ovf", {31'h0, bus.overflow}, 0);
        sb.delete();
        @(negedge clk); rst = 1'b0;
        run_op(1'b1, 16'd0, 16'd4, 16'd24, 1'b0);
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
